// File: rtl/pcie_trans_mc_pkg.sv
// Shared types and default sizing for the multi-channel PCIe transaction buffer.
// Build option: define PCIE_TRANS_RR_EN for round-robin VC arbitration
// (otherwise lowest VC index wins).
package pcie_trans_mc_pkg;

    localparam int unsigned DEF_DATA_W     = 6;
    localparam int unsigned DEF_NUM_VC     = 2;
    localparam int unsigned DEF_NUM_DEST   = 2;
    localparam int unsigned DEF_MAIN_DEPTH = 8;
    localparam int unsigned DEF_VC_DEPTH   = 16;
    localparam int unsigned DEF_D_DEPTH    = 4;
    localparam int unsigned DEF_TH_W       = 5;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_INIT   = 4'd1,
        ST_IDLE   = 4'd2,
        ST_ACTIVE = 4'd3,
        ST_ERROR  = 4'd4
    } state_e;

endpackage

// File: rtl/pcie_trans_mc_if.sv
// Ingress/egress bus of the transaction buffer: push side and per-destination pop side.
interface pcie_trans_mc_if
    import pcie_trans_mc_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_DEST = DEF_NUM_DEST
);
    logic                         push;
    logic [DATA_W-1:0]            data_in;
    logic [NUM_DEST-1:0]          pop;
    logic [NUM_DEST*DATA_W-1:0]   data_out;
    logic [NUM_DEST-1:0]          valid_out;
    logic [NUM_DEST-1:0]          can_pop;
    logic                         main_pause;

    modport master (
        output push, data_in, pop,
        input  data_out, valid_out, can_pop, main_pause
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, valid_out, can_pop, main_pause
    );
endinterface

// File: rtl/pcie_trans_mc_fifo_sync.sv
// Synchronous FIFO with show-ahead head, full/empty and programmable almost-full.
module pcie_trans_mc_fifo_sync #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TH_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [TH_W-1:0]   th_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              afull_o
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              do_wr_c, do_rd_c;
    logic [TH_W-1:0]   th_eff_c;

    // Writes into a full FIFO are discarded; reads of an empty FIFO are ignored.
    assign do_wr_c  = wr_en_i && !full_o;
    assign do_rd_c  = rd_en_i && !empty_o;
    assign full_o   = (cnt_q == CNT_W'(DEPTH));
    assign empty_o  = (cnt_q == '0);
    assign th_eff_c = (th_i == '0) ? TH_W'(DEPTH) : th_i;
    assign afull_o  = (TH_W'(cnt_q) >= th_eff_c);
    assign head_o   = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd_c) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + CNT_W'(do_wr_c) - CNT_W'(do_rd_c);
        end
    end

    // Storage array, contents are don't-care once pointers are reset.
    always_ff @(posedge clk) begin
        if (do_wr_c) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/pcie_trans_mc.sv
// Multi-channel PCIe transaction buffer: main FIFO -> per-VC FIFOs -> per-destination FIFOs.
// Build option: PCIE_TRANS_RR_EN selects round-robin VC arbitration, else fixed priority.
module pcie_trans_mc
    import pcie_trans_mc_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned NUM_VC     = DEF_NUM_VC,
    parameter int unsigned NUM_DEST   = DEF_NUM_DEST,
    parameter int unsigned MAIN_DEPTH = DEF_MAIN_DEPTH,
    parameter int unsigned VC_DEPTH   = DEF_VC_DEPTH,
    parameter int unsigned D_DEPTH    = DEF_D_DEPTH,
    parameter int unsigned TH_W       = DEF_TH_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [TH_W-1:0]  th_main,
    input  logic [TH_W-1:0]  th_vc,
    input  logic [TH_W-1:0]  th_d,
    pcie_trans_mc_if.slave   bus,
    output logic [3:0]       state,
    output logic [3:0]       next_state
);
    localparam int unsigned VC_W    = $clog2(NUM_VC);
    localparam int unsigned DST_W   = $clog2(NUM_DEST);
    localparam int unsigned DST_LSB = DATA_W - DST_W;
    localparam int unsigned VC_LSB  = DST_LSB - VC_W;

    state_e                     state_q, state_d;
    logic [TH_W-1:0]            th_main_q, th_vc_q, th_d_q;
    logic                       run_c, overflow_c, any_ne_c, xfer_c;

    logic                       main_wr_c, main_rd_c, main_full, main_empty, main_afull;
    logic [DATA_W-1:0]          main_head;
    logic [VC_W-1:0]            main_vc_c;

    logic [NUM_VC-1:0]          vc_wr_c, vc_rd_c, vc_full, vc_empty, vc_afull, vc_elig_c;
    logic [DATA_W-1:0]          vc_head [NUM_VC];
    logic [DST_W-1:0]           vc_dst_c [NUM_VC];

    logic [NUM_DEST-1:0]        d_wr_c, d_rd_c, d_full, d_empty, d_afull;
    logic [DATA_W-1:0]          d_head [NUM_DEST];
    logic [DATA_W-1:0]          d_wdata_c;

    logic                       gnt_vld_c;
    logic [VC_W-1:0]            gnt_idx_c, arb_base_c;
    logic [NUM_DEST*DATA_W-1:0] data_out_q;
    logic [NUM_DEST-1:0]        valid_q;

    // Transfers and pushes only run in IDLE/ACTIVE; a push into a full main FIFO is fatal.
    assign run_c      = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign main_wr_c  = bus.push && run_c;
    assign overflow_c = main_wr_c && main_full;
    assign any_ne_c   = !main_empty || !(&vc_empty) || !(&d_empty);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_RESET;
        else        state_q <= state_d;
    end

    // FSM next-state logic; overflow outranks an init request.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE,
            ST_ACTIVE: begin
                if (overflow_c)    state_d = ST_ERROR;
                else if (init)     state_d = ST_INIT;
                else if (any_ne_c) state_d = ST_ACTIVE;
                else               state_d = ST_IDLE;
            end
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_RESET;
        endcase
    end

    assign state      = state_q;
    assign next_state = state_d;

    // Threshold latches, loaded every INIT cycle while init is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_main_q <= TH_W'(MAIN_DEPTH);
            th_vc_q   <= TH_W'(VC_DEPTH);
            th_d_q    <= TH_W'(D_DEPTH);
        end else if ((state_q == ST_INIT) && init) begin
            th_main_q <= th_main;
            th_vc_q   <= th_vc;
            th_d_q    <= th_d;
        end
    end

    // Main->VC router: the main head moves only if its VC FIFO has room (head-of-line stall).
    assign main_vc_c = main_head[VC_LSB +: VC_W];
    assign main_rd_c = run_c && !main_empty && !vc_afull[main_vc_c] && !vc_full[main_vc_c];

    always_comb begin
        vc_wr_c = '0;
        if (main_rd_c) vc_wr_c[main_vc_c] = 1'b1;
    end

    // A VC is eligible when its head's destination FIFO can take a word.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            vc_dst_c[v]  = vc_head[v][DST_LSB +: DST_W];
            vc_elig_c[v] = !vc_empty[v] && !d_afull[vc_dst_c[v]] && !d_full[vc_dst_c[v]];
        end
    end

`ifdef PCIE_TRANS_RR_EN
    logic [VC_W-1:0] rr_q;

    // Round-robin pointer moves past the last granted VC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      rr_q <= '0;
        else if (xfer_c) rr_q <= gnt_idx_c + VC_W'(1);
    end

    assign arb_base_c = rr_q;
`else
    assign arb_base_c = '0;
`endif

    // First eligible VC scanning upward from the base (modulo NUM_VC).
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_idx_c = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (!gnt_vld_c && vc_elig_c[arb_base_c + VC_W'(i)]) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = arb_base_c + VC_W'(i);
            end
        end
    end

    assign xfer_c = run_c && gnt_vld_c;

    // VC->dest move of the granted head.
    always_comb begin
        vc_rd_c   = '0;
        d_wr_c    = '0;
        d_wdata_c = vc_head[gnt_idx_c];
        if (xfer_c) begin
            vc_rd_c[gnt_idx_c]           = 1'b1;
            d_wr_c[vc_dst_c[gnt_idx_c]]  = 1'b1;
        end
    end

    // Pops are honoured in every state; empty pops are ignored.
    assign d_rd_c = bus.pop & ~d_empty;

    // Registered per-destination read data and one-cycle valid pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_q <= '0;
            valid_q    <= '0;
        end else begin
            valid_q <= d_rd_c;
            for (int k = 0; k < NUM_DEST; k++) begin
                if (d_rd_c[k]) data_out_q[k*DATA_W +: DATA_W] <= d_head[k];
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.valid_out  = valid_q;
    assign bus.can_pop    = ~d_empty;
    assign bus.main_pause = main_afull;

    pcie_trans_mc_fifo_sync #(.DATA_W(DATA_W), .DEPTH(MAIN_DEPTH), .TH_W(TH_W)) u_main (
        .clk(clk), .reset(reset),
        .wr_en_i(main_wr_c), .wr_data_i(bus.data_in), .rd_en_i(main_rd_c), .th_i(th_main_q),
        .head_o(main_head), .full_o(main_full), .empty_o(main_empty), .afull_o(main_afull)
    );

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        pcie_trans_mc_fifo_sync #(.DATA_W(DATA_W), .DEPTH(VC_DEPTH), .TH_W(TH_W)) u_vc (
            .clk(clk), .reset(reset),
            .wr_en_i(vc_wr_c[g]), .wr_data_i(main_head), .rd_en_i(vc_rd_c[g]), .th_i(th_vc_q),
            .head_o(vc_head[g]), .full_o(vc_full[g]), .empty_o(vc_empty[g]), .afull_o(vc_afull[g])
        );
    end

    for (genvar g = 0; g < NUM_DEST; g++) begin : g_dst
        pcie_trans_mc_fifo_sync #(.DATA_W(DATA_W), .DEPTH(D_DEPTH), .TH_W(TH_W)) u_dst (
            .clk(clk), .reset(reset),
            .wr_en_i(d_wr_c[g]), .wr_data_i(d_wdata_c), .rd_en_i(d_rd_c[g]), .th_i(th_d_q),
            .head_o(d_head[g]), .full_o(d_full[g]), .empty_o(d_empty[g]), .afull_o(d_afull[g])
        );
    end

endmodule

// File: tb/tb_pcie_trans_mc.sv
// Randomized bench for pcie_trans_mc against a queue-based reference model.
module tb_pcie_trans_mc;
    localparam int DW = 6, NV = 2, ND = 2, MD = 8, VD = 16, DD = 4, TW = 5;
    localparam int DST_LSB = DW - 1;
    localparam int VC_LSB  = DW - 2;

    logic          clk = 1'b0;
    logic          reset, init;
    logic [TW-1:0] th_main, th_vc, th_d;
    logic [3:0]    state, next_state;

    pcie_trans_mc_if #(.DATA_W(DW), .NUM_DEST(ND)) bus ();

    pcie_trans_mc #(
        .DATA_W(DW), .NUM_VC(NV), .NUM_DEST(ND), .MAIN_DEPTH(MD),
        .VC_DEPTH(VD), .D_DEPTH(DD), .TH_W(TW)
    ) dut (
        .clk(clk), .reset(reset), .init(init),
        .th_main(th_main), .th_vc(th_vc), .th_d(th_d),
        .bus(bus), .state(state), .next_state(next_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain queues per stage plus the control state.
    logic [DW-1:0]    mq[$];
    logic [DW-1:0]    vq[NV][$];
    logic [DW-1:0]    dq[ND][$];
    int               m_state, m_th_main, m_th_vc, m_th_d, m_rr;
    logic [ND*DW-1:0] m_dout;
    logic [ND-1:0]    m_valid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int room(input int th, input int depth);
        int e;
        e = (th == 0) ? depth : th;
        return (e < depth) ? e : depth;
    endfunction

    function automatic bit busy();
        bit b;
        b = (mq.size() != 0);
        for (int i = 0; i < NV; i++) if (vq[i].size() != 0) b = 1'b1;
        for (int i = 0; i < ND; i++) if (dq[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < NV; i++) vq[i].delete();
        for (int i = 0; i < ND; i++) dq[i].delete();
        m_state = 0; m_th_main = MD; m_th_vc = VD; m_th_d = DD; m_rr = 0;
        m_dout = '0; m_valid = '0;
    endtask

    function automatic int model_next();
        case (m_state)
            0:       return 1;
            1:       return init ? 1 : 2;
            2, 3: begin
                if (bus.push && mq.size() == MD) return 4;
                if (init) return 1;
                return busy() ? 3 : 2;
            end
            default: return 4;
        endcase
    endfunction

    task automatic model_step();
        bit            run, mv;
        int            hv, g, nxt, pre_main;
        logic [DW-1:0] w;
        run      = (m_state == 2) || (m_state == 3);
        nxt      = model_next();
        pre_main = mq.size();
        if (m_state == 1 && init) begin
            m_th_main = int'(th_main); m_th_vc = int'(th_vc); m_th_d = int'(th_d);
        end
        mv = 1'b0; hv = 0;
        if (run && mq.size() > 0) begin
            hv = int'(mq[0] >> VC_LSB) % NV;
            mv = (vq[hv].size() < room(m_th_vc, VD));
        end
        g = -1;
        if (run) begin
            for (int i = 0; i < NV; i++) begin
                int v;
`ifdef PCIE_TRANS_RR_EN
                v = (m_rr + i) % NV;
`else
                v = i;
`endif
                if (g < 0 && vq[v].size() > 0 &&
                    dq[int'(vq[v][0] >> DST_LSB) % ND].size() < room(m_th_d, DD)) g = v;
            end
        end
        m_valid = '0;
        for (int k = 0; k < ND; k++) begin
            if (bus.pop[k] && dq[k].size() > 0) begin
                m_valid[k] = 1'b1;
                m_dout[k*DW +: DW] = dq[k].pop_front();
            end
        end
        if (g >= 0) begin
            w = vq[g].pop_front();
            dq[int'(w >> DST_LSB) % ND].push_back(w);
            m_rr = (g + 1) % NV;
        end
        if (mv) begin
            w = mq.pop_front();
            vq[hv].push_back(w);
        end
        if (run && bus.push && pre_main < MD) mq.push_back(bus.data_in);
        m_state = nxt;
    endtask

    // One clock: drive inputs, check next_state, advance model, check outputs.
    task automatic tick(input bit rst_v, input bit init_v, input bit push_v,
                        input logic [DW-1:0] d, input logic [ND-1:0] pop_v);
        logic [ND-1:0] cp;
        reset = rst_v; init = init_v; bus.push = push_v; bus.data_in = d; bus.pop = pop_v;
        if (!rst_v) model_reset();
        #1;
        check_eq("next_state", 32'(next_state), 32'(model_next()));
        @(posedge clk);
        if (rst_v) model_step();
        else       model_reset();
        #1;
        for (int k = 0; k < ND; k++) cp[k] = (dq[k].size() != 0);
        check_eq("state", 32'(state), 32'(m_state));
        check_eq("can_pop", 32'(bus.can_pop), 32'(cp));
        check_eq("main_pause", 32'(bus.main_pause), 32'(mq.size() >= room(m_th_main, 1 << 20) && mq.size() >= 0 ? (mq.size() >= ((m_th_main == 0) ? MD : m_th_main)) : 0));
        check_eq("data_out", 32'(bus.data_out), 32'(m_dout));
        check_eq("valid_out", 32'(bus.valid_out), 32'(m_valid));
    endtask

    task automatic do_init(input int tm, input int tv, input int td);
        th_main = TW'(tm); th_vc = TW'(tv); th_d = TW'(td);
        tick(0, 0, 0, '0, '0);
        tick(0, 0, 0, '0, '0);
        tick(1, 1, 0, '0, '0);
        tick(1, 1, 0, '0, '0);
        tick(1, 0, 0, '0, '0);
    endtask

    initial begin
        reset = 1'b0; init = 1'b0; bus.push = 1'b0; bus.data_in = '0; bus.pop = '0;
        th_main = TW'(6); th_vc = TW'(12); th_d = TW'(3);

        // Reset and threshold load
        tick(0, 0, 0, '0, '0);
        tick(0, 0, 0, '0, '0);
        check_eq("t1_rst_state", 32'(state), 32'd0);
        check_eq("t1_rst_cp", 32'(bus.can_pop), 32'd0);
        check_eq("t1_rst_dout", 32'(bus.data_out), 32'd0);
        check_eq("t1_rst_pause", 32'(bus.main_pause), 32'd0);
        tick(1, 1, 0, '0, '0);
        check_eq("t1_init", 32'(state), 32'd1);
        tick(1, 1, 0, '0, '0);
        tick(1, 0, 0, '0, '0);
        check_eq("t1_idle", 32'(state), 32'd2);

        // Single word latency to dest1 and pop
        tick(1, 0, 1, 6'b10_1010, '0);
        check_eq("t2_cp_n", 32'(bus.can_pop), 32'd0);
        tick(1, 0, 0, '0, '0);
        check_eq("t2_cp_n1", 32'(bus.can_pop), 32'd0);
        tick(1, 0, 0, '0, '0);
        check_eq("t2_cp_n2", 32'(bus.can_pop), 32'b10);
        tick(1, 0, 0, '0, 2'b10);
        check_eq("t2_dout", 32'(bus.data_out[11:6]), 32'h2A);
        check_eq("t2_valid", 32'(bus.valid_out), 32'b10);
        tick(1, 0, 0, '0, '0);
        check_eq("t2_valid_off", 32'(bus.valid_out), 32'd0);
        check_eq("t2_cp_empty", 32'(bus.can_pop), 32'd0);

        // Dest0 stalled, VC1 to dest1 keeps flowing
        for (int i = 0; i < 10; i++) tick(1, 0, 1, 6'h00, '0);
        tick(1, 0, 1, 6'b11_0001, '0);
        tick(1, 0, 1, 6'b11_0001, '0);
        for (int i = 0; i < 8; i++) tick(1, 0, 0, '0, '0);
        check_eq("t4_cp_both", 32'(bus.can_pop), 32'b11);
        tick(1, 0, 0, '0, 2'b10);
        check_eq("t4_d1_data", 32'(bus.data_out[11:6]), 32'h31);

        // Randomized rounds with varying traffic mix and thresholds
        for (int r = 0; r < 6; r++) begin
            int p_push, p_pop;
            p_push = (r % 2 == 0) ? 90 : 50;
            p_pop  = (r < 2) ? 5 : ((r < 4) ? 40 : 80);
            if (r == 0) do_init(6, 12, 3);
            else do_init($urandom_range(0, 10), $urandom_range(0, 20), $urandom_range(0, 5));
            for (int c = 0; c < 300; c++) begin
                bit            iv, rv;
                logic [ND-1:0] pv;
                iv = ($urandom_range(0, 63) == 0);
                rv = ($urandom_range(0, 399) != 0);
                if (iv) begin
                    th_main = TW'($urandom_range(0, 10));
                    th_vc   = TW'($urandom_range(0, 20));
                    th_d    = TW'($urandom_range(0, 5));
                end
                for (int k = 0; k < ND; k++) pv[k] = ($urandom_range(0, 99) < p_pop);
                tick(rv, iv, ($urandom_range(0, 99) < p_push), DW'($urandom_range(0, 63)), pv);
            end
        end

        // Overflow into ERROR, pops still drain, reset recovers
        do_init(6, 12, 3);
        for (int i = 0; i < 60; i++) tick(1, 0, 1, 6'h00, '0);
        check_eq("t6_error", 32'(state), 32'd4);
        check_eq("t6_cp0", 32'(bus.can_pop), 32'b01);
        for (int i = 0; i < 5; i++) tick(1, 0, 0, '0, 2'b01);
        check_eq("t6_still_err", 32'(state), 32'd4);
        tick(0, 0, 0, '0, '0);
        check_eq("t6_rst", 32'(state), 32'd0);
        check_eq("t6_rst_cp", 32'(bus.can_pop), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
